gbf_read_responder: RTL and testbench

//  Responder end of the PE-to-GBF read bus. One instance serves one GBF lane (one Quad_Port_Ram port).
//  It arbitrates the level requests raised by the PEs on that lane and turns the winner's (i,k) index into a GBF address.
//  It then issues the RAM read and returns the word with a one-cycle grant pulse to the winning PE.

---
 rtl/gbf_bus_pkg.sv | 24 ++
 rtl/gbf_read_responder_if.sv | 41 ++++
 rtl/gbf_read_responder_rr_arbiter.sv | 36 +++
 rtl/gbf_read_responder.sv | 116 +++++++++++
 tb/tb_gbf_read_responder.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/gbf_bus_pkg.sv
// gbf_bus_pkg
//   Shared definitions for the PE-to-GBF read bus, used by both the input and
//   the weight lanes.
//   - IDX_W    : default width of one (row/col) index field
//   - state_e  : responder FSM encoding (IDLE, ISSUE, CAPTURE)
//   - gbf_addr : row*stride + col at 32 bits; callers size the result so that
//                an out-of-range address is still visible before truncation
package gbf_bus_pkg;

    localparam int IDX_W = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2
    } state_e;

    function automatic logic [31:0] gbf_addr(input logic [31:0] row,
                                             input logic [31:0] col,
                                             input logic [31:0] stride);
        return row * stride + col;
    endfunction

endpackage

// File: rtl/gbf_read_responder_if.sv
// gbf_read_responder_if
//   PE/RAM-side bundle of one GBF read lane.
//   master : PEs and RAM (drive req, idx_row, idx_col, ram_q)
//   slave  : the responder (drives ram_addr, grant, data_out, err, busy)
//   req       N_REQ        level request per PE, held until its grant pulse
//   idx_row   N_REQ*IDX_W  row index of PE n at [n*IDX_W +: IDX_W]
//   idx_col   N_REQ*IDX_W  column index, packed likewise
//   ram_addr  AW           GBF port address
//   ram_q     WIDTH        GBF read data, one cycle after ram_addr
//   grant     N_REQ        one-hot single-cycle pulse, data_out valid
//   data_out  WIDTH        returned word
//   err       1            out-of-range flag, pulses with grant
//   busy      1            responder not in IDLE
interface gbf_read_responder_if #(
    parameter int N_REQ = 2,
    parameter int IDX_W = gbf_bus_pkg::IDX_W,
    parameter int WIDTH = 32,
    parameter int AW    = 5
) ();

    logic [N_REQ-1:0]       req;
    logic [N_REQ*IDX_W-1:0] idx_row;
    logic [N_REQ*IDX_W-1:0] idx_col;
    logic [AW-1:0]          ram_addr;
    logic [WIDTH-1:0]       ram_q;
    logic [N_REQ-1:0]       grant;
    logic [WIDTH-1:0]       data_out;
    logic                   err;
    logic                   busy;

    modport master (
        output req, idx_row, idx_col, ram_q,
        input  ram_addr, grant, data_out, err, busy
    );

    modport slave (
        input  req, idx_row, idx_col, ram_q,
        output ram_addr, grant, data_out, err, busy
    );

endinterface

// File: rtl/gbf_read_responder_rr_arbiter.sv
// rr_arbiter
//   Purely combinational round-robin pick: the first set request bit at or
//   after i_rr, wrapping from N-1 back to 0.
//   i_req  N   request vector
//   i_rr   IW  search start position (always < N)
//   o_gnt  N   one-hot winner (zero when no request)
//   o_id   IW  binary id of the winner
//   o_any  1   at least one request present
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_rr,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_id,
    output logic          o_any
);

    always_comb begin
        int idx;
        idx   = 0;
        o_gnt = '0;
        o_id  = '0;
        o_any = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(i_rr) + k) % N;
            if (!o_any && i_req[idx]) begin
                o_any      = 1'b1;
                o_gnt[idx] = 1'b1;
                o_id       = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/gbf_read_responder.sv
// gbf_read_responder
//   Responder end of one GBF read lane. Arbitrates the PEs' level requests
//   round-robin, turns the winner's (row,col) into a GBF address, performs the
//   registered RAM read and returns the word with a one-cycle grant pulse.
//   One transaction every three cycles: IDLE -> ISSUE -> CAPTURE.
//   i_clk  1      rising-edge clock
//   i_rst  1      synchronous active-high reset
//   bus    slave  request/index inputs, RAM port, grant/data/err/busy outputs
module gbf_read_responder #(
    parameter int WIDTH  = 32,
    parameter int HEIGHT = 32,
    parameter int N_REQ  = 2,
    parameter int STRIDE = 3,
    parameter int IDX_W  = gbf_bus_pkg::IDX_W
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    gbf_read_responder_if.slave  bus
);
    import gbf_bus_pkg::*;

    localparam int AW  = $clog2(HEIGHT);
    // Wide enough to hold row*STRIDE+col so out-of-range sums are not wrapped.
    localparam int FW  = AW + IDX_W + 1;
    localparam int RRW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_e           r_state;
    logic [RRW-1:0]   r_rr;
    logic [RRW-1:0]   r_win_id;
    logic [N_REQ-1:0] r_win_oh;
    logic [AW-1:0]    r_ram_addr;
    logic             r_oob;
    logic [N_REQ-1:0] r_grant;
    logic             r_err;
    logic             r_busy;

    logic [N_REQ-1:0] w_gnt;
    logic [RRW-1:0]   w_id;
    logic             w_any;
    logic [IDX_W-1:0] w_row;
    logic [IDX_W-1:0] w_col;
    logic [FW-1:0]    w_addr_full;
    logic             w_oob;
    logic [RRW-1:0]   w_rr_next;

    rr_arbiter #(.N(N_REQ), .IW(RRW)) u_arb (
        .i_req (bus.req),
        .i_rr  (r_rr),
        .o_gnt (w_gnt),
        .o_id  (w_id),
        .o_any (w_any)
    );

    assign w_row       = bus.idx_row[int'(w_id)*IDX_W +: IDX_W];
    assign w_col       = bus.idx_col[int'(w_id)*IDX_W +: IDX_W];
    assign w_addr_full = FW'(gbf_addr(32'(w_row), 32'(w_col), 32'(STRIDE)));
    assign w_oob       = (w_addr_full >= FW'(HEIGHT));
    assign w_rr_next   = (r_win_id == RRW'(N_REQ - 1)) ? '0 : r_win_id + 1'b1;

    // The address (or 0 when out of range) is registered at the same edge that
    // latches the winner, so it sits on the RAM port for the whole ISSUE cycle
    // and the registered RAM presents ram_q during CAPTURE.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_rr       <= '0;
            r_win_id   <= '0;
            r_win_oh   <= '0;
            r_ram_addr <= '0;
            r_oob      <= 1'b0;
            r_grant    <= '0;
            r_err      <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_win_id   <= w_id;
                        r_win_oh   <= w_gnt;
                        r_ram_addr <= w_oob ? '0 : w_addr_full[AW-1:0];
                        r_oob      <= w_oob;
                        r_busy     <= 1'b1;
                        r_state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_grant <= r_win_oh;
                    r_err   <= r_oob;
                    r_state <= CAPTURE;
                end
                CAPTURE: begin
                    r_grant <= '0;
                    r_err   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_rr    <= w_rr_next;
                    r_state <= IDLE;
                end
                default: begin
                    r_grant <= '0;
                    r_err   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.ram_addr = r_ram_addr;
    assign bus.grant    = r_grant;
    assign bus.err      = r_err;
    assign bus.busy     = r_busy;
    // ram_q is the RAM's own output register; gating it by the grant/err flops
    // keeps data_out at zero outside the grant pulse and on out-of-range reads.
    assign bus.data_out = (|r_grant && !r_err) ? bus.ram_q : '0;

endmodule

// File: tb/tb_gbf_read_responder.sv
module tb_gbf_read_responder;

    typedef struct packed {
        logic [1:0]  g;
        logic [31:0] d;
        logic        e;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [31:0] mem [0:31];
    exp_t        sb[$];
    int          n_checks = 0;
    int          n_errs   = 0;
    int          w;

    gbf_read_responder_if #(.N_REQ(2), .IDX_W(8), .WIDTH(32), .AW(5)) bus ();

    gbf_read_responder #(
        .WIDTH(32), .HEIGHT(32), .N_REQ(2), .STRIDE(3), .IDX_W(8)
    ) u_dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered RAM model: one-cycle read latency.
    always @(posedge clk) bus.ram_q <= mem[bus.ram_addr];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every grant pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        if (rst === 1'b0 && bus.grant !== 2'b00) begin
            chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_grant", 64'(bus.grant), 64'(e.g));
                chk("sb_data", 64'(bus.data_out), 64'(e.d));
                chk("sb_err", 64'(bus.err), 64'(e.e));
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_idx(input int pe, input int row, input int col);
        bus.idx_row[pe*8 +: 8] = 8'(row);
        bus.idx_col[pe*8 +: 8] = 8'(col);
    endtask

    task automatic push(input int pe, input int row, input int col);
        exp_t e;
        int   a;
        a      = row * 3 + col;
        e.g    = 2'b00;
        e.g[pe] = 1'b1;
        if (a < 32) begin
            e.d = mem[a];
            e.e = 1'b0;
        end else begin
            e.d = 32'd0;
            e.e = 1'b1;
        end
        sb.push_back(e);
    endtask

    task automatic wait_grant(output int waited);
        waited = 0;
        for (int i = 0; i < 12; i++) begin
            cyc(1);
            waited++;
            if (bus.grant !== 2'b00) break;
        end
    endtask

    // Wait for PE pe's grant, then drop its request in the following cycle.
    task automatic serve(input int pe);
        int         wt;
        logic [1:0] oh;
        oh     = 2'b00;
        oh[pe] = 1'b1;
        wait_grant(wt);
        chk("serve_grant", 64'(bus.grant), 64'(oh));
        cyc(1);
        bus.req[pe] = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'hA000_0000 + 32'(i) * 32'h0000_0111;
        mem[5]      = 32'hDEAD_BEEF;
        bus.ram_q   = '0;
        bus.idx_row = '0;
        bus.idx_col = '0;

        // Reset held two cycles with both PEs requesting.
        rst = 1'b1;
        set_idx(0, 0, 0);
        set_idx(1, 1, 2);
        bus.req = 2'b11;
        cyc(2);
        chk("rst_grant", 64'(bus.grant), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_data", 64'(bus.data_out), 64'd0);
        chk("rst_err", 64'(bus.err), 64'd0);
        chk("rst_addr", 64'(bus.ram_addr), 64'd0);
        push(0, 0, 0);
        rst = 1'b0;
        cyc(1);
        chk("post_rst_grant", 64'(bus.grant), 64'd0);
        chk("post_rst_busy", 64'(bus.busy), 64'd1);
        cyc(1);
        chk("first_grant", 64'(bus.grant), 64'b01);
        cyc(1);
        bus.req[0] = 1'b0;

        // Single read by PE1: row 1, col 2 -> address 5.
        push(1, 1, 2);
        cyc(1);
        chk("issue_addr", 64'(bus.ram_addr), 64'd5);
        chk("issue_busy", 64'(bus.busy), 64'd1);
        chk("issue_nogrant", 64'(bus.grant), 64'd0);
        cyc(1);
        chk("read_grant", 64'(bus.grant), 64'b10);
        chk("read_data", 64'(bus.data_out), 64'hDEAD_BEEF);
        chk("read_err", 64'(bus.err), 64'd0);
        cyc(1);
        bus.req[1] = 1'b0;

        // Round-robin with both PEs re-raising after each grant.
        set_idx(0, 0, 1);
        set_idx(1, 2, 0);
        for (int k = 0; k < 4; k++) push(k % 2, (k % 2) * 2, 1 - (k % 2));
        bus.req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            serve(k % 2);
            cyc(1);
            if (k < 2) bus.req[k % 2] = 1'b1;
        end

        // Out of range: 10*3+5 = 35.
        set_idx(0, 10, 5);
        push(0, 10, 5);
        bus.req = 2'b01;
        cyc(1);
        chk("oob_addr", 64'(bus.ram_addr), 64'd0);
        serve(0);

        // rr advanced past PE0; also the top in-range address 31.
        set_idx(0, 0, 4);
        set_idx(1, 10, 1);
        push(1, 10, 1);
        push(0, 0, 4);
        bus.req = 2'b11;
        serve(1);
        serve(0);

        // Reset while PE0's transaction is in ISSUE; rr returns to 0.
        set_idx(0, 0, 0);
        set_idx(1, 1, 2);
        bus.req = 2'b01;
        cyc(1);
        rst = 1'b1;
        cyc(1);
        chk("midrst_grant", 64'(bus.grant), 64'd0);
        chk("midrst_busy", 64'(bus.busy), 64'd0);
        rst = 1'b0;
        bus.req = 2'b11;
        push(0, 0, 0);
        push(1, 1, 2);
        serve(0);
        serve(1);

        // Reset mid-op with only PE1 requesting; it is still served afterwards.
        bus.req = 2'b10;
        cyc(1);
        rst = 1'b1;
        cyc(1);
        chk("midrst2_grant", 64'(bus.grant), 64'd0);
        rst = 1'b0;
        push(1, 1, 2);
        serve(1);

        // Late request: PE0 raises during PE1's CAPTURE and is not lost.
        set_idx(0, 0, 4);
        push(1, 1, 2);
        push(0, 0, 4);
        bus.req = 2'b10;
        wait_grant(w);
        chk("late_pe1_grant", 64'(bus.grant), 64'b10);
        bus.req[0] = 1'b1;
        cyc(1);
        bus.req[1] = 1'b0;
        wait_grant(w);
        chk("late_pe0_grant", 64'(bus.grant), 64'b01);
        chk("late_pe0_latency", 64'(w), 64'd2);
        cyc(1);
        bus.req[0] = 1'b0;

        cyc(4);
        chk("sb_drained", 64'(sb.size()), 64'd0);
        chk("idle_busy", 64'(bus.busy), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
